// File: rtl/spi_flash_reader.sv
// spi_flash_reader: fetches one 32-bit little-endian word from a SPI NOR flash
// using the 0x03 READ command (mode 0, single-bit MOSI/MISO).
module spi_flash_reader #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1
);

   localparam int unsigned CNT_W  = 5;
   localparam int unsigned BIT_W  = 6;
   localparam int unsigned TX_W   = 31;
   localparam logic [7:0]  READ_CMD = 8'h03;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 2);
   localparam logic [BIT_W-1:0] LAST_CMD_BIT  = BIT_W'(7);
   localparam logic [BIT_W-1:0] LAST_ADDR_BIT = BIT_W'(31);
   localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(63);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      GAP
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [TX_W-1:0]   tx_sr;
   logic [TX_W-1:0]   rx_sr;
   logic [31:0]       rx_word;

   // Ready is decoded from state so the first edge after reset can accept.
   assign req_ready = (state == IDLE) && !wb_rst_i;

   // Last sampled bit completes the word; first byte received is the low byte.
   assign rx_word = {rx_sr, flash_io1};

   // Transfer sequencer: bit timing, MOSI shifting, MISO assembly, response.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         flash_csb <= 1'b1;
         flash_clk <= 1'b0;
         flash_io0 <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= CMD;
                  flash_csb <= 1'b0;
                  flash_clk <= 1'b0;
                  flash_io0 <= READ_CMD[7];
                  tx_sr     <= {READ_CMD[6:0], req_addr};
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
               end
            end
            CMD, ADDR, DATA: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + CNT_W'(1);
               end else begin
                  div_cnt <= '0;
                  if (!flash_clk) begin
                     flash_clk <= 1'b1;
                  end else begin
                     // End of a high phase: sample MISO and start the next bit.
                     if (state == DATA) begin
                        rx_sr <= {rx_sr[TX_W-2:0], flash_io1};
                     end
                     flash_clk <= 1'b0;
                     if (bit_cnt == LAST_BIT) begin
                        state     <= GAP;
                        flash_csb <= 1'b1;
                        flash_io0 <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {rx_word[7:0], rx_word[15:8],
                                      rx_word[23:16], rx_word[31:24]};
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_CMD_BIT) begin
                           state <= ADDR;
                        end
                        if (bit_cnt == LAST_ADDR_BIT) begin
                           state <= DATA;
                        end
                        if (bit_cnt < LAST_ADDR_BIT) begin
                           flash_io0 <= tx_sr[TX_W-1];
                           tx_sr     <= {tx_sr[TX_W-2:0], 1'b0};
                        end else begin
                           flash_io0 <= 1'b0;
                        end
                     end
                  end
               end
            end
            GAP: begin
               // Hold chip select high so the next accept lands 2*CLK_DIV after release.
               if (div_cnt == GAP_LAST) begin
                  state   <= IDLE;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: two reader instances (CLK_DIV=2 and CLK_DIV=1), each
// attached to a behavioural flash and checked every cycle against a timing model.
module tb_spi_flash_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic        req_valid [2];
   logic        req_ready [2];
   logic [23:0] req_addr  [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_data  [2];
   logic        csb  [2];
   logic        fclk [2];
   logic        io0  [2];

   logic [7:0] mem [logic [23:0]];

   always #5 clk = ~clk;

   // Edge counter: value after edge k is k.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] fbyte(input logic [23:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] fword(input logic [23:0] a);
      return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
   endfunction

   task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane%0d cyc=%0d actual=%h expected=%h", name, g, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int D = (g == 0) ? 2 : 1;

      logic        io1_r = 1'b0;
      int          rise_cnt = 0;
      logic [31:0] dec = '0;
      logic [7:0]  cur_byte;
      int          k;

      bit          has_acc = 1'b0;
      int          acc_edge = 0;
      logic [23:0] acc_addr = '0;
      logic [31:0] exp_data = '0;
      logic [31:0] frame;
      int          t;
      int          n;
      logic        e_csb, e_clk, e_io0, e_rv, e_rdy;

      spi_flash_reader #(.CLK_DIV(D)) u_dut (
         .wb_clk_i  (clk),
         .wb_rst_i  (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_data  (rsp_data[g]),
         .flash_csb (csb[g]),
         .flash_clk (fclk[g]),
         .flash_io0 (io0[g]),
         .flash_io1 (io1_r)
      );

      // Flash: decode MOSI on rising clock, shift data out on rising clock.
      initial forever begin
         @(posedge fclk[g] or negedge csb[g]);
         if (!fclk[g]) begin
            rise_cnt = 0;
            dec = '0;
         end else if (!csb[g]) begin
            if (rise_cnt < 32) begin
               dec = {dec[30:0], io0[g]};
            end else begin
               k = rise_cnt - 32;
               cur_byte = fbyte(dec[23:0] + 24'(k / 8));
               io1_r = cur_byte[7 - (k % 8)];
            end
            rise_cnt++;
         end
      end

      // Timing model: outputs as a function of cycles since the accept edge.
      initial forever begin
         @(negedge clk);
         if (rst) begin
            has_acc  = 1'b0;
            exp_data = '0;
            chk(g, "rst_csb", 32'(csb[g]), 32'd1);
            chk(g, "rst_clk", 32'(fclk[g]), 32'd0);
            chk(g, "rst_io0", 32'(io0[g]), 32'd0);
            chk(g, "rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
            chk(g, "rst_rsp_data", rsp_data[g], 32'd0);
            chk(g, "rst_ready", 32'(req_ready[g]), 32'd0);
         end else begin
            e_csb = 1'b1; e_clk = 1'b0; e_io0 = 1'b0; e_rv = 1'b0; e_rdy = 1'b1;
            if (has_acc) begin
               t = cyc - acc_edge;
               frame = {8'h03, acc_addr};
               if (t < 128 * D) begin
                  e_csb = 1'b0;
                  e_clk = ((t / D) % 2) == 1;
                  n = t / (2 * D);
                  if (n < 32) e_io0 = frame[31 - n];
               end
               if (t == 128 * D) begin
                  e_rv = 1'b1;
                  exp_data = fword(acc_addr);
               end
               e_rdy = (t >= 130 * D - 1);
            end
            chk(g, "csb", 32'(csb[g]), 32'(e_csb));
            chk(g, "flash_clk", 32'(fclk[g]), 32'(e_clk));
            chk(g, "io0", 32'(io0[g]), 32'(e_io0));
            chk(g, "rsp_valid", 32'(rsp_valid[g]), 32'(e_rv));
            chk(g, "rsp_data", rsp_data[g], exp_data);
            chk(g, "req_ready", 32'(req_ready[g]), 32'(e_rdy));
            if (req_valid[g] && e_rdy) begin
               has_acc  = 1'b1;
               acc_edge = cyc + 1;
               acc_addr = req_addr[g];
            end
         end
      end
   end

   // Wait for a response pulse, optionally scrambling req_addr meanwhile.
   task automatic wait_rsp(input int g, input bit toggle, output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (toggle) req_addr[g] = 24'($urandom);
         if (rsp_valid[g]) begin
            at = cyc;
            break;
         end
      end
      chk(g, "rsp_arrived", 32'(at >= 0), 32'd1);
   endtask

   int t0, r1, r2;
   logic [31:0] d1;

   initial begin
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;
         req_addr[g]  = '0;
      end
      mem[24'h000100] = 8'h11; mem[24'h000101] = 8'h22;
      mem[24'h000102] = 8'h33; mem[24'h000103] = 8'h44;
      mem[24'hFFFFFC] = 8'hA5; mem[24'hFFFFFD] = 8'h5A;
      mem[24'hFFFFFE] = 8'hC3; mem[24'hFFFFFF] = 8'h3C;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk(g, "init_csb", 32'(csb[g]), 32'd1);
         chk(g, "init_ready", 32'(req_ready[g]), 32'd0);
         chk(g, "init_rsp_data", rsp_data[g], 32'd0);
      end

      // Read 0x000100 on the first edge after reset, address scrambled after accept.
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid[0] = 1'b1;
      req_addr[0]  = 24'h000100;
      @(posedge clk); #1;
      t0 = cyc;
      req_valid[0] = 1'b0;
      wait_rsp(0, 1'b1, r1);
      chk(0, "lat_div2", 32'(r1 - t0), 32'd256);
      chk(0, "data_100", rsp_data[0], 32'h44332211);
      chk(0, "mosi_decode", lane[0].dec, 32'h03000100);
      chk(0, "rise_count", 32'(lane[0].rise_cnt), 32'd64);

      // Back-to-back with req_valid held high.
      repeat (10) @(posedge clk);
      #1;
      req_valid[0] = 1'b1;
      req_addr[0]  = 24'h000000;
      @(posedge clk); #1;
      req_addr[0]  = 24'h000004;
      wait_rsp(0, 1'b0, r1);
      d1 = rsp_data[0];
      wait_rsp(0, 1'b0, r2);
      req_valid[0] = 1'b0;
      chk(0, "b2b_spacing", 32'(r2 - r1), 32'd260);
      chk(0, "b2b_data0", d1, 32'h59585B5A);
      chk(0, "b2b_data4", rsp_data[0], 32'h5D5C5F5E);

      // Reset 100 cycles into a transfer, then a clean retry.
      repeat (10) @(posedge clk);
      #1;
      req_valid[0] = 1'b1;
      req_addr[0]  = 24'h000100;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk(0, "abort_csb", 32'(csb[0]), 32'd1);
      chk(0, "abort_clk", 32'(fclk[0]), 32'd0);
      chk(0, "abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid[0] = 1'b1;
      req_addr[0]  = 24'h000100;
      @(posedge clk); #1;
      t0 = cyc;
      req_valid[0] = 1'b0;
      wait_rsp(0, 1'b0, r1);
      chk(0, "retry_lat", 32'(r1 - t0), 32'd256);
      chk(0, "retry_data", rsp_data[0], 32'h44332211);

      // CLK_DIV=1 instance at the top of the address space.
      repeat (5) @(posedge clk);
      #1;
      req_valid[1] = 1'b1;
      req_addr[1]  = 24'hFFFFFC;
      @(posedge clk); #1;
      t0 = cyc;
      req_valid[1] = 1'b0;
      wait_rsp(1, 1'b0, r1);
      chk(1, "lat_div1", 32'(r1 - t0), 32'd128);
      chk(1, "data_fffffc", rsp_data[1], 32'h3CC35AA5);
      chk(1, "mosi_decode_div1", lane[1].dec, 32'h03FFFFFC);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2, is the flash_clk half-period in wb_clk_i cycles; legal range 1..15.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset; asynchronous and active-high.
REQ-004 req_valid  input  1  read request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_addr  input  24  flash byte address; sampled only on accept.
REQ-007 rsp_valid  output  1  one-cycle pulse; rsp_data valid this cycle.
REQ-008 rsp_data  output  32  assembled little-endian word.
REQ-009 flash_csb  output  1  flash chip select, active-low.
REQ-010 flash_clk  output  1  SPI clock, mode 0, idles low.
REQ-011 flash_io0  output  1  MOSI, command and address bits.
REQ-012 flash_io1  input  1  MISO, read data bits.

Function
REQ-013 A request SHALL be accepted at a rising edge where req_valid and req_ready are both 1 (the accept edge, T0).
REQ-014 The block SHALL use states IDLE, CMD, ADDR, DATA and GAP.
- IDLE->CMD on accept.
- CMD->ADDR after 8 bits.
- ADDR->DATA after 24 bits.
- DATA->GAP after 32 bits.
- GAP->IDLE after 2*CLK_DIV cycles.
REQ-015 req_ready SHALL be 1 only in IDLE and never while wb_rst_i is high.
REQ-016 On the accept edge, flash_csb SHALL go low and flash_io0 SHALL present bit 7 of command 0x03.
REQ-017 Each SPI bit n (0..63) SHALL drive flash_clk low for CLK_DIV cycles starting at edge T0+2n*CLK_DIV, then high for CLK_DIV cycles.
REQ-018 flash_io0 SHALL change only at the start of a low phase: command bits first (MSB first, bits 0..7), then req_addr[23:0] (MSB first, bits 8..31).
REQ-019 flash_io0 SHALL be 0 during DATA, GAP and IDLE.
REQ-020 flash_io1 SHALL be sampled at the edge ending the high phase of bits 32..63 (the edge where flash_clk returns low).
REQ-021 Data assembly: the first byte received (MSB first) SHALL map to rsp_data[7:0], the second to [15:8], the third to [23:16] and the fourth to [31:24].
REQ-022 At edge T0+128*CLK_DIV, the block SHALL in the same edge set flash_clk=0, set flash_csb=1, pulse rsp_valid=1 for exactly one cycle, and update rsp_data.
REQ-023 Latency from the accept edge to rsp_valid SHALL be exactly 128*CLK_DIV cycles (256 at default).
REQ-024 rsp_data SHALL hold its value until the next rsp_valid.
REQ-025 There is no response backpressure; the consumer must take rsp_valid when it pulses.
REQ-026 flash_csb SHALL remain high for at least 2*CLK_DIV cycles before the next accept, so back-to-back requests are spaced 130*CLK_DIV cycles apart.
REQ-027 req_valid and req_addr changes after the accept edge SHALL have no effect on the transfer in progress.
REQ-028 The internal counters SHALL be wide enough for 64 bits and CLK_DIV up to 15, with no wrap-around within a transfer.

Reset
REQ-029 While wb_rst_i=1, the outputs SHALL immediately be:
- flash_csb=1
- flash_clk=0
- flash_io0=0
- rsp_valid=0
- rsp_data=0
- req_ready=0
- state=IDLE
REQ-030 Reset asserted mid-transfer SHALL abort the transfer without producing rsp_valid.
REQ-031 The first accept after reset is released SHALL be possible at the first rising edge after wb_rst_i falls.

Verification
REQ-032 Flash bytes 0x100..0x103 = 11,22,33,44; request addr 0x000100 at CLK_DIV=2 -> rsp_valid exactly 256 cycles after accept, rsp_data=0x44332211.
REQ-033 The bench SHALL decode MOSI on rising flash_clk -> 0x03, 0x00, 0x01, 0x00; flash_csb low for exactly 256 cycles; flash_clk has 64 rising edges.
REQ-034 req_valid held high continuously with addrs 0x000000 then 0x000004 -> two responses 260 cycles apart, flash_csb high for at least 4 cycles between them, data matching the flash contents.
REQ-035 wb_rst_i pulsed high at cycle 100 of a transfer -> flash_csb=1 and flash_clk=0 the same cycle, no rsp_valid; the next request completes correctly.
REQ-036 CLK_DIV=1, addr 0xFFFFFC, flash bytes A5,5A,C3,3C -> latency 128 cycles, rsp_data=0x3CC35AA5.
REQ-037 req_addr toggled randomly after accept -> MOSI address bits equal the value sampled at accept.
